// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera capture path.
// Build option: CAM_LINE_CHECK_EN adds the per-line byte counter in the top.
package cam_pkg;

  localparam int unsigned IMG_W_DEF = 160;
  localparam int unsigned IMG_H_DEF = 120;
  localparam int unsigned AW_DEF    = 15;
  localparam int unsigned CAM_DW    = 8;
  localparam int unsigned PX_W      = 12;

  typedef enum logic [1:0] {
    ST_WAIT_VS    = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_BYTE1      = 2'd2,
    ST_BYTE2      = 2'd3
  } cam_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Keep the top 4 bits of each RGB565 channel.
  function automatic rgb444_t rgb565_to_444(input logic [CAM_DW-1:0] b1,
                                            input logic [CAM_DW-1:0] b2);
    rgb444_t px;
    px.r = b1[7:4];
    px.g = {b1[2:0], b2[7]};
    px.b = b2[4:1];
    return px;
  endfunction

endpackage

// File: rtl/cam_pin_sync.sv
// Two-flop synchronisers for the camera pins plus a pclk rising-edge strobe.
// The strobe and the stage-2 copies of vsync/href/data are registered together
// so every consumer sees them aligned on the same clk cycle.
module cam_pin_sync
  import cam_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pclk_i,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic [CAM_DW-1:0] data_i,
  output logic              pe_o,
  output logic              vsync_o,
  output logic              href_o,
  output logic [CAM_DW-1:0] data_o
);

  logic [2:0]        pclk_q;
  logic [1:0]        vsync_q;
  logic [1:0]        href_q;
  logic [CAM_DW-1:0] data_s1_q;
  logic [CAM_DW-1:0] data_s2_q;
  logic              pe_q;
  logic              vsync_al_q;
  logic              href_al_q;
  logic [CAM_DW-1:0] data_al_q;

  // Synchroniser chains and edge detect (stage 2 vs stage 3).
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_q     <= '0;
      vsync_q    <= '0;
      href_q     <= '0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      pe_q       <= 1'b0;
      vsync_al_q <= 1'b0;
      href_al_q  <= 1'b0;
      data_al_q  <= '0;
    end else begin
      pclk_q     <= {pclk_q[1:0], pclk_i};
      vsync_q    <= {vsync_q[0], vsync_i};
      href_q     <= {href_q[0], href_i};
      data_s1_q  <= data_i;
      data_s2_q  <= data_s1_q;
      pe_q       <= pclk_q[1] & ~pclk_q[2];
      vsync_al_q <= vsync_q[1];
      href_al_q  <= href_q[1];
      data_al_q  <= data_s2_q;
    end
  end

  assign pe_o    = pe_q;
  assign vsync_o = vsync_al_q;
  assign href_o  = href_al_q;
  assign data_o  = data_al_q;

endmodule

// File: rtl/cam_capture_rgb444.sv
// Camera receive path: pins -> RGB444 pixel writes into the frame buffer.
// Build option: CAM_LINE_CHECK_EN enables the sticky line-length check on line_err.
module cam_capture_rgb444
  import cam_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CAM_pclk,
  input  logic              CAM_vsync,
  input  logic              CAM_href,
  input  logic [CAM_DW-1:0] CAM_px_data,
  output logic [AW-1:0]     mem_px_addr,
  output logic [PX_W-1:0]   mem_px_data,
  output logic              px_wr,
  output logic              frame_done,
  output logic              line_err
);

  localparam int unsigned NPIX      = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  logic              pe;
  logic              vs;
  logic              hr;
  logic [CAM_DW-1:0] d;

  cam_state_e        state_q, state_d;
  logic [CAM_DW-1:0] b1_q, b1_d;
  logic [AW-1:0]     addr_q, addr_d;
  rgb444_t           pix_q, pix_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic              wrote_q, wrote_d;

  cam_pin_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .pclk_i  (CAM_pclk),
    .vsync_i (CAM_vsync),
    .href_i  (CAM_href),
    .data_i  (CAM_px_data),
    .pe_o    (pe),
    .vsync_o (vs),
    .href_o  (hr),
    .data_o  (d)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT_VS;
      b1_q    <= '0;
      addr_q  <= '0;
      pix_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      wrote_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b1_q    <= b1_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      full_q  <= full_d;
      wrote_q <= wrote_d;
    end
  end

  // Next-state: byte pairing, write strobe, address advance and overflow hold.
  always_comb begin
    state_d = state_q;
    b1_d    = b1_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    full_d  = full_q;
    wrote_d = wrote_q;

    // Address moves on the cycle after a write; the last slot holds instead.
    if (wr_q) begin
      if (addr_q == LAST_ADDR) full_d = 1'b1;
      else                     addr_d = addr_q + AW'(1);
    end

    if (state_q == ST_WAIT_FRAME) begin
      addr_d  = '0;
      full_d  = 1'b0;
      wrote_d = 1'b0;
    end

    if (pe) begin
      if ((state_q != ST_WAIT_VS) && vs) begin
        // Vsync outranks any byte on the same edge and ends the frame.
        state_d = ST_WAIT_FRAME;
        done_d  = wrote_q;
        addr_d  = '0;
        full_d  = 1'b0;
        wrote_d = 1'b0;
      end else begin
        unique case (state_q)
          ST_WAIT_VS:    if (vs)  state_d = ST_WAIT_FRAME;
          ST_WAIT_FRAME: if (!vs) state_d = ST_BYTE1;
          ST_BYTE1: begin
            if (hr) begin
              b1_d    = d;
              state_d = ST_BYTE2;
            end
          end
          ST_BYTE2: begin
            state_d = ST_BYTE1;
            if (hr && !full_q) begin
              wr_d    = 1'b1;
              pix_d   = rgb565_to_444(b1_q, d);
              wrote_d = 1'b1;
            end
          end
          default: state_d = ST_WAIT_VS;
        endcase
      end
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = pix_q;
  assign px_wr       = wr_q;
  assign frame_done  = done_q;

`ifdef CAM_LINE_CHECK_EN
  localparam int unsigned LINE_BYTES = 2 * IMG_W;
  localparam int unsigned CNT_W      = $clog2(LINE_BYTES + 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             href_prev_q, href_prev_d;
  logic             err_q, err_d;
  logic             in_line_c;

  assign in_line_c = (state_q == ST_BYTE1) || (state_q == ST_BYTE2);

  // Line byte counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      href_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      href_prev_q <= href_prev_d;
      err_q       <= err_d;
    end
  end

  // Count bytes per line; flag a wrong count at href fall or a dangling byte.
  always_comb begin
    cnt_d       = cnt_q;
    href_prev_d = href_prev_q;
    err_d       = err_q;
    if (pe) begin
      href_prev_d = hr;
      if (in_line_c && !vs) begin
        if (hr) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          if (href_prev_q) begin
            if (cnt_q != CNT_W'(LINE_BYTES)) err_d = 1'b1;
            cnt_d = '0;
          end
          if (state_q == ST_BYTE2) err_d = 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign line_err = err_q;
`else
  assign line_err = 1'b0;
`endif

endmodule
